// File: rtl/string_store_sequencer_if.sv
// Decoder/register-file/memory-facing signals of the STOS sequencer.
// With STRING_DIR_FLAG_EN defined the bundle also carries the direction flag df.
interface string_store_sequencer_if;
  logic        start;
  logic        rep;
  logic [1:0]  size;
  logic [31:0] edi_in;
  logic [31:0] ecx_in;
  logic [31:0] eax_in;
  logic        mem_ack;
`ifdef STRING_DIR_FLAG_EN
  logic        df;
`endif
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [3:0]  read_or_write;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
`ifdef STRING_DIR_FLAG_EN
    output df,
`endif
    output start, rep, size, edi_in, ecx_in, eax_in, mem_ack,
    input  mem_wr_req, mem_addr, mem_wdata, mem_be, read_or_write, write_data,
    input  busy, done, error
  );

  modport slave (
`ifdef STRING_DIR_FLAG_EN
    input  df,
`endif
    input  start, rep, size, edi_in, ecx_in, eax_in, mem_ack,
    output mem_wr_req, mem_addr, mem_wdata, mem_be, read_or_write, write_data,
    output busy, done, error
  );
endinterface

// File: rtl/string_store_sequencer.sv
// STOSB/STOSW/STOSD sequencer: one memory write per element, EDI/ECX write-back.
// Optional feature: define STRING_DIR_FLAG_EN to add the df direction-flag input.
module string_store_sequencer #(
  parameter logic [3:0] EDI_SEL  = 4'h6,
  parameter logic [3:0] ECX_SEL  = 4'h1,
  parameter logic [3:0] NOP_SEL  = 4'hF,
  parameter int         MAX_WAIT = 15
) (
  input logic                     clock_6,
  input logic                     reset,
  string_store_sequencer_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, STORE, WAIT, WB_EDI, WB_ECX, DONE, ERR
  } state_t;

  state_t              state;
  logic [31:0]         edi_q;
  logic [31:0]         count_q;
  logic [31:0]         eax_q;
  logic                rep_q;
  logic [1:0]          size_q;
  logic [WAIT_W-1:0]   wait_cnt;
`ifdef STRING_DIR_FLAG_EN
  logic                df_q;
`endif

  logic [31:0] step;
  logic [31:0] edi_next;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    step       = 32'd4;
    lane_be    = 4'b1111;
    lane_wdata = eax_q;
    case (size_q)
      2'b00: begin
        step       = 32'd1;
        lane_be    = 4'b0001 << edi_q[1:0];
        lane_wdata = {4{eax_q[7:0]}};
      end
      2'b01: begin
        step       = 32'd2;
        lane_be    = 4'b0011 << {edi_q[1], 1'b0};
        lane_wdata = {2{eax_q[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef STRING_DIR_FLAG_EN
  assign edi_next = df_q ? edi_q - step : edi_q + step;
`else
  assign edi_next = edi_q + step;
`endif

  // Outputs are registered: each transition loads the values the next state presents.
  // NOTE: state and outputs use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clock_6) begin
    if (reset) begin
      state             <= IDLE;
      edi_q             <= '0;
      count_q           <= '0;
      eax_q             <= '0;
      rep_q             <= 1'b0;
      size_q            <= '0;
      wait_cnt          <= '0;
`ifdef STRING_DIR_FLAG_EN
      df_q              <= 1'b0;
`endif
      bus.mem_wr_req    <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_be        <= '0;
      bus.read_or_write <= NOP_SEL;
      bus.write_data    <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            edi_q    <= bus.edi_in;
            count_q  <= bus.ecx_in;
            eax_q    <= bus.eax_in;
            rep_q    <= bus.rep;
            size_q   <= bus.size;
`ifdef STRING_DIR_FLAG_EN
            df_q     <= bus.df;
`endif
            bus.busy <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (rep_q && count_q == 32'd0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.mem_wr_req <= 1'b1;
            bus.mem_addr   <= edi_q;
            bus.mem_be     <= lane_be;
            bus.mem_wdata  <= lane_wdata;
            state          <= STORE;
          end
        end
        STORE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // An ack arriving on the expiry cycle still completes the element.
          if (bus.mem_ack) begin
            bus.mem_wr_req    <= 1'b0;
            bus.read_or_write <= EDI_SEL;
            bus.write_data    <= edi_next;
            state             <= WB_EDI;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
              bus.mem_wr_req <= 1'b0;
              bus.done       <= 1'b1;
              bus.error      <= 1'b1;
              state          <= ERR;
            end
          end
        end
        WB_EDI: begin
          edi_q <= edi_next;
          if (rep_q) begin
            bus.read_or_write <= ECX_SEL;
            bus.write_data    <= count_q - 32'd1;
            state             <= WB_ECX;
          end else begin
            bus.read_or_write <= NOP_SEL;
            bus.done          <= 1'b1;
            state             <= DONE;
          end
        end
        WB_ECX: begin
          count_q           <= count_q - 32'd1;
          bus.read_or_write <= NOP_SEL;
          state             <= CHECK;
        end
        DONE, ERR: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_string_store_sequencer.sv
// Table-driven bench for string_store_sequencer with a store/write-back scoreboard.
module tb_string_store_sequencer;
  logic clock_6 = 1'b0;
  logic reset;
  always #5 clock_6 = ~clock_6;

  string_store_sequencer_if bus();
  string_store_sequencer dut (.clock_6(clock_6), .reset(reset), .bus(bus));

  typedef struct {
    logic        rep;
    logic [1:0]  size;
    logic [31:0] edi;
    logic [31:0] ecx;
    logic [31:0] eax;
    logic        df;
    int          ack_at;   // 0: ack always high, -1: never, n: raised at cycle n
    logic        exp_err;
    logic [31:0] exp_edi;
    int          exp_stores;
    int          exp_cycles;
  } vec_t;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } store_t;
  typedef struct { logic [3:0] sel; logic [31:0] data; } wb_t;

  store_t      store_q[$];
  wb_t         wb_q[$];
  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_miscomp = 0;
  int          n_stores = 0;
  logic [31:0] last_edi_wb;
  logic        prev_req = 1'b0;
  store_t      s_exp;
  wb_t         w_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected stores and write-backs for one instruction.
  task automatic push_model(input vec_t v);
    logic [31:0] e, c, step;
    store_t      s;
    int          n;
    e    = v.edi;
    c    = v.ecx;
    step = (v.size == 2'b00) ? 32'd1 : (v.size == 2'b01) ? 32'd2 : 32'd4;
    n    = v.rep ? int'(v.ecx) : 1;
    for (int k = 0; k < n; k++) begin
      s.addr = e;
      s.be   = 4'b0000;
      case (v.size)
        2'b00: begin s.be[e[1:0]] = 1'b1; s.wdata = {4{v.eax[7:0]}}; end
        2'b01: begin s.be = e[1] ? 4'b1100 : 4'b0011; s.wdata = {2{v.eax[15:0]}}; end
        default: begin s.be = 4'b1111; s.wdata = v.eax; end
      endcase
      store_q.push_back(s);
      if (v.exp_err) break;
      e = v.df ? e - step : e + step;
      wb_q.push_back('{sel: 4'h6, data: e});
      if (v.rep) begin
        c = c - 32'd1;
        wb_q.push_back('{sel: 4'h1, data: c});
      end
    end
  endtask

  task automatic drive_start(input vec_t v);
    bus.start  = 1'b1;
    bus.rep    = v.rep;
    bus.size   = v.size;
    bus.edi_in = v.edi;
    bus.ecx_in = v.ecx;
    bus.eax_in = v.eax;
`ifdef STRING_DIR_FLAG_EN
    bus.df     = v.df;
`endif
  endtask

  // Monitor: compare each new memory request and each register write-back.
  always @(negedge clock_6) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus.mem_wr_req && !prev_req) begin
        n_stores++;
        if (store_q.size() == 0) begin
          check("unexpected_store", 32'(bus.mem_wr_req), 32'd0);
        end else begin
          s_exp = store_q.pop_front();
          check("store_addr", bus.mem_addr, s_exp.addr);
          check("store_be", 32'(bus.mem_be), 32'(s_exp.be));
          check("store_wdata", bus.mem_wdata, s_exp.wdata);
        end
      end
      if (bus.read_or_write != 4'hF) begin
        if (bus.read_or_write == 4'h6) last_edi_wb = bus.write_data;
        if (wb_q.size() == 0) begin
          check("unexpected_wb", 32'(bus.read_or_write), 32'hF);
        end else begin
          w_exp = wb_q.pop_front();
          check("wb_sel", 32'(bus.read_or_write), 32'(w_exp.sel));
          check("wb_data", bus.write_data, w_exp.data);
        end
      end
      prev_req = bus.mem_wr_req;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   cycles;
    logic err_at_done;
    string tag;
    tag = $sformatf("v%0d", idx);
    push_model(v);
    @(negedge clock_6);
    n_stores    = 0;
    last_edi_wb = v.edi;
    drive_start(v);
    bus.mem_ack = (v.ack_at == 0);
    @(negedge clock_6);
    bus.start = 1'b0;
    cycles    = 1;
    while (!bus.done && cycles < 200) begin
      if (v.ack_at > 0 && cycles >= v.ack_at) bus.mem_ack = 1'b1;
      @(negedge clock_6);
      cycles++;
    end
    err_at_done = bus.error;
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(v.exp_cycles));
    check({tag, "_error"}, 32'(err_at_done), 32'(v.exp_err));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_stores"}, 32'(n_stores), 32'(v.exp_stores));
    check({tag, "_final_edi"}, last_edi_wb, v.exp_edi);
    @(negedge clock_6);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_store_q_empty"}, 32'(store_q.size()), 32'd0);
    check({tag, "_wb_q_empty"}, 32'(wb_q.size()), 32'd0);
    store_q.delete();
    wb_q.delete();
  endtask

  initial begin
    //        rep   size   edi           ecx    eax           df    ack  err   exp_edi       st cyc
    vecs.push_back(vec_t'{1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0000_1004, 1, 5});
    vecs.push_back(vec_t'{1'b1, 2'b00, 32'h0000_2001, 32'd3, 32'h0000_0041, 1'b0, 0, 1'b0, 32'h0000_2004, 3, 17});
    vecs.push_back(vec_t'{1'b1, 2'b00, 32'h0000_3000, 32'd0, 32'h0000_0055, 1'b0, 0, 1'b0, 32'h0000_3000, 0, 2});
    vecs.push_back(vec_t'{1'b0, 2'b01, 32'h0000_3002, 32'd0, 32'hABCD_1234, 1'b0, 0, 1'b0, 32'h0000_3004, 1, 5});
    vecs.push_back(vec_t'{1'b1, 2'b10, 32'hFFFF_FFFC, 32'd2, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0000_0004, 2, 12});
    vecs.push_back(vec_t'{1'b1, 2'b11, 32'h0000_0020, 32'd1, 32'h0102_0304, 1'b0, 0, 1'b0, 32'h0000_0024, 1, 7});
    vecs.push_back(vec_t'{1'b0, 2'b00, 32'h0000_0050, 32'd0, 32'h0000_007E, 1'b0, -1, 1'b1, 32'h0000_0050, 1, 18});
    vecs.push_back(vec_t'{1'b0, 2'b00, 32'h0000_0060, 32'd0, 32'h0000_0033, 1'b0, 17, 1'b0, 32'h0000_0061, 1, 19});
`ifdef STRING_DIR_FLAG_EN
    vecs.push_back(vec_t'{1'b0, 2'b01, 32'h0000_0000, 32'd0, 32'h0000_BEEF, 1'b1, 0, 1'b0, 32'hFFFF_FFFE, 1, 5});
    vecs.push_back(vec_t'{1'b1, 2'b00, 32'h0000_0002, 32'd2, 32'h0000_0099, 1'b1, 0, 1'b0, 32'h0000_0000, 2, 12});
`endif

    bus.start   = 1'b0;
    bus.rep     = 1'b0;
    bus.size    = 2'b00;
    bus.edi_in  = '0;
    bus.ecx_in  = '0;
    bus.eax_in  = '0;
    bus.mem_ack = 1'b0;
`ifdef STRING_DIR_FLAG_EN
    bus.df      = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clock_6);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_error", 32'(bus.error), 32'd0);
    check("reset_req", 32'(bus.mem_wr_req), 32'd0);
    check("reset_rw", 32'(bus.read_or_write), 32'hF);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during WAIT of the second REP element abandons the instruction.
    begin
      vec_t v;
      v = vec_t'{1'b1, 2'b00, 32'h0000_0100, 32'd3, 32'h0000_00A5, 1'b0, 0, 1'b0, 32'h0, 0, 0};
      store_q.push_back('{addr: 32'h0000_0100, be: 4'b0001, wdata: 32'hA5A5_A5A5});
      wb_q.push_back('{sel: 4'h6, data: 32'h0000_0101});
      wb_q.push_back('{sel: 4'h1, data: 32'd2});
      store_q.push_back('{addr: 32'h0000_0101, be: 4'b0010, wdata: 32'hA5A5_A5A5});
      @(negedge clock_6);
      drive_start(v);
      bus.mem_ack = 1'b1;
      @(negedge clock_6);
      bus.start = 1'b0;
      for (int k = 1; k < 8; k++) begin
        if (k == 4) bus.mem_ack = 1'b0;
        @(negedge clock_6);
      end
      check("rst_mid_in_wait_req", 32'(bus.mem_wr_req), 32'd1);
      check("rst_mid_in_wait_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(negedge clock_6);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_req", 32'(bus.mem_wr_req), 32'd0);
      check("rst_mid_rw", 32'(bus.read_or_write), 32'hF);
      check("rst_mid_done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      bus.mem_ack = 1'b1;
      repeat (10) @(negedge clock_6);
      check("rst_mid_busy_after", 32'(bus.busy), 32'd0);
      check("rst_mid_store_q_empty", 32'(store_q.size()), 32'd0);
      check("rst_mid_wb_q_empty", 32'(wb_q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end
endmodule
